// File: rtl/coin_pkg.sv
// Shared widths, coin values, switch indices and FSM state type for the
// coin/credit front end.
package coin_pkg;

    localparam int CREDIT_W = 4;

    localparam logic [CREDIT_W-1:0] COIN_100_UNITS = 4'd1;
    localparam logic [CREDIT_W-1:0] COIN_500_UNITS = 4'd5;

    localparam int SW_COIN_100 = 0;
    localparam int SW_COIN_500 = 1;
    localparam int SW_CONFIRM  = 2;
    localparam int SW_CANCEL   = 3;
    localparam int NUM_SW      = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECTING,
        REQUEST,
        REFUND
    } fe_state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one raw
// slide switch.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg    <= 1'b0;
            sync2_reg    <= 1'b0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync1_reg    <= raw;
            sync2_reg    <= sync1_reg;
            stable_d_reg <= stable_reg;
            // Any sample matching the accepted level restarts the count.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign pulse = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/coin_credit_front_end.sv
// Conditions the four raw switches, accumulates credit and hands it to the
// downstream vend logic through a req/ack handshake, with cancel/refund.
module coin_credit_front_end
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_CREDIT      = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_100_sw,
    input  logic                coin_500_sw,
    input  logic                confirm_sw,
    input  logic                cancel_sw,
    input  logic                vend_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount,
    output logic                coin_accepted,
    output logic                coin_rejected,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);

    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] sw_pulse;

    assign sw_raw = {cancel_sw, confirm_sw, coin_500_sw, coin_100_sw};

    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_deb
            switch_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock(clock),
                .reset(reset),
                .raw  (sw_raw[gi]),
                .pulse(sw_pulse[gi])
            );
        end
    endgenerate

    logic p100, p500, p_confirm, p_cancel;
    assign p100      = sw_pulse[SW_COIN_100];
    assign p500      = sw_pulse[SW_COIN_500];
    assign p_confirm = sw_pulse[SW_CONFIRM];
    assign p_cancel  = sw_pulse[SW_CANCEL];

    fe_state_t state_reg;
    logic      pending_reg;

    // At most one coin is applied per cycle; a coin_100 colliding with a
    // coin_500 waits one cycle in the pending flag.
    logic                coin_take;
    logic [CREDIT_W-1:0] coin_val;
    logic                extra_reject;
    logic                pending_upd;
    logic [CREDIT_W:0]   sum_wide;
    logic                coin_fits;
    logic [CREDIT_W-1:0] credit_upd;
    logic                any_coin;

    always_comb begin
        coin_take    = 1'b0;
        coin_val     = '0;
        extra_reject = 1'b0;
        pending_upd  = 1'b0;
        if (p500) begin
            coin_take    = 1'b1;
            coin_val     = COIN_500_UNITS;
            extra_reject = p100 & pending_reg;
            pending_upd  = p100 | pending_reg;
        end else if (pending_reg) begin
            coin_take    = 1'b1;
            coin_val     = COIN_100_UNITS;
            extra_reject = p100;
        end else if (p100) begin
            coin_take = 1'b1;
            coin_val  = COIN_100_UNITS;
        end
    end

    assign sum_wide   = {1'b0, credit} + {1'b0, coin_val};
    assign coin_fits  = coin_take && (sum_wide <= MAX_SUM);
    assign credit_upd = coin_fits ? sum_wide[CREDIT_W-1:0] : credit;
    assign any_coin   = p100 | p500 | pending_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            pending_reg   <= 1'b0;
            credit        <= '0;
            vend_req      <= 1'b0;
            refund_valid  <= 1'b0;
            refund_amount <= '0;
            coin_accepted <= 1'b0;
            coin_rejected <= 1'b0;
            busy          <= 1'b0;
        end else begin
            coin_accepted <= 1'b0;
            coin_rejected <= 1'b0;
            refund_valid  <= 1'b0;
            case (state_reg)
                IDLE, COLLECTING: begin
                    if (p_cancel && state_reg == COLLECTING) begin
                        coin_rejected <= any_coin;
                        pending_reg   <= 1'b0;
                        refund_valid  <= 1'b1;
                        refund_amount <= credit;
                        busy          <= 1'b1;
                        state_reg     <= REFUND;
                    end else begin
                        coin_accepted <= coin_fits;
                        coin_rejected <= (coin_take & ~coin_fits) | extra_reject;
                        pending_reg   <= pending_upd;
                        credit        <= credit_upd;
                        // Confirm sees the credit including this cycle's coin.
                        if (p_confirm && credit_upd != '0) begin
                            vend_req  <= 1'b1;
                            busy      <= 1'b1;
                            state_reg <= REQUEST;
                        end else begin
                            state_reg <= (credit_upd != '0) ? COLLECTING : IDLE;
                        end
                    end
                end
                REQUEST: begin
                    coin_rejected <= any_coin;
                    pending_reg   <= 1'b0;
                    if (vend_ack) begin
                        vend_req  <= 1'b0;
                        credit    <= '0;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                REFUND: begin
                    coin_rejected <= any_coin;
                    pending_reg   <= 1'b0;
                    credit        <= '0;
                    refund_amount <= '0;
                    busy          <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_credit_front_end.sv
// Directed test-plan steps followed by random switch activity, all checked
// every cycle against a behavioural model of the front end.
module tb_coin_credit_front_end;

    localparam int D    = 4;
    localparam int MAXC = 9;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] sw_drv;
    logic       vend_ack;
    logic [3:0] credit;
    logic       vend_req;
    logic       refund_valid;
    logic [3:0] refund_amount;
    logic       coin_accepted;
    logic       coin_rejected;
    logic       busy;

    always #5 clock = ~clock;

    coin_credit_front_end #(
        .DEBOUNCE_CYCLES(D),
        .MAX_CREDIT     (MAXC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_100_sw  (sw_drv[0]),
        .coin_500_sw  (sw_drv[1]),
        .confirm_sw   (sw_drv[2]),
        .cancel_sw    (sw_drv[3]),
        .vend_ack     (vend_ack),
        .credit       (credit),
        .vend_req     (vend_req),
        .refund_valid (refund_valid),
        .refund_amount(refund_amount),
        .coin_accepted(coin_accepted),
        .coin_rejected(coin_rejected),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: per-switch sample history and accepted level, plus credit/mode.
    bit sh[4][D+2];
    bit stab[4];
    bit ev[4];
    int m_credit;
    int m_mode;      // 0 open for coins, 1 awaiting ack, 2 refunding
    bit m_pend;
    int e_ramt;
    bit e_acc, e_rej, e_rv, e_vreq, e_busy;

    int obs_acc, obs_rej, last_ramt, acc_cycle;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            stab[i] = 1'b0;
            ev[i]   = 1'b0;
            for (int k = 0; k < D + 2; k++) sh[i][k] = 1'b0;
        end
        m_credit = 0; m_mode = 0; m_pend = 1'b0; e_ramt = 0;
        e_acc = 1'b0; e_rej = 1'b0; e_rv = 1'b0; e_vreq = 1'b0; e_busy = 1'b0;
    endtask

    // A level is accepted once the synchronised samples have disagreed with
    // the accepted level for D consecutive cycles; the rising edge of the
    // accepted level reaches the credit logic one cycle later.
    task automatic deb_update();
        bit all_diff;
        for (int i = 0; i < 4; i++) begin
            for (int k = D + 1; k > 0; k--) sh[i][k] = sh[i][k-1];
            sh[i][0] = sw_drv[i];
            ev[i] = 1'b0;
            all_diff = 1'b1;
            for (int k = 2; k < D + 2; k++) if (sh[i][k] == stab[i]) all_diff = 1'b0;
            if (all_diff) begin
                stab[i] = ~stab[i];
                ev[i]   = stab[i];
            end
        end
    endtask

    task automatic model_fsm(input bit c100, input bit c500, input bit conf,
                             input bit canc, input bit ack);
        bit any;
        int v;
        e_acc = 1'b0; e_rej = 1'b0; e_rv = 1'b0;
        any = c100 | c500 | m_pend;
        if (m_mode == 1) begin
            e_rej  = any;
            m_pend = 1'b0;
            if (ack) begin
                m_mode = 0; m_credit = 0; e_vreq = 1'b0;
            end
        end else if (m_mode == 2) begin
            e_rej  = any;
            m_pend = 1'b0;
            m_credit = 0; e_ramt = 0; m_mode = 0;
        end else if (canc && m_credit > 0) begin
            e_rej  = any;
            m_pend = 1'b0;
            e_rv   = 1'b1;
            e_ramt = m_credit;
            m_mode = 2;
        end else begin
            v = 0;
            if (c500) begin
                v = 5;
                if (c100) begin
                    if (m_pend) e_rej = 1'b1;
                    else        m_pend = 1'b1;
                end
            end else if (m_pend) begin
                v = 1;
                m_pend = 1'b0;
                if (c100) e_rej = 1'b1;
            end else if (c100) begin
                v = 1;
            end
            if (v != 0) begin
                if (m_credit + v <= MAXC) begin
                    m_credit += v;
                    e_acc = 1'b1;
                end else begin
                    e_rej = 1'b1;
                end
            end
            if (conf && m_credit > 0) begin
                m_mode = 1;
                e_vreq = 1'b1;
            end
        end
        e_busy = (m_mode != 0);
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            model_fsm(ev[0], ev[1], ev[2], ev[3], vend_ack);
            deb_update();
        end
        #1;
        cyc++;
        chk("credit",        credit,        m_credit);
        chk("vend_req",      vend_req,      e_vreq);
        chk("refund_valid",  refund_valid,  e_rv);
        chk("refund_amount", refund_amount, e_ramt);
        chk("coin_accepted", coin_accepted, e_acc);
        chk("coin_rejected", coin_rejected, e_rej);
        chk("busy",          busy,          e_busy);
        if (coin_accepted === 1'b1) obs_acc++;
        if (coin_rejected === 1'b1) obs_rej++;
        if (refund_valid === 1'b1) last_ramt = refund_amount;
    endtask

    task automatic press(input int idx);
        sw_drv[idx] = 1'b1;
        repeat (10) step();
        sw_drv[idx] = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        int a0, r0;
        model_reset();
        obs_acc = 0; obs_rej = 0; last_ramt = 0; acc_cycle = 0;
        reset = 1'b1; sw_drv = 4'b0000; vend_ack = 1'b0;
        repeat (3) step();
        chk("reset_credit", credit, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        repeat (2) step();

        // Short glitch must not register.
        a0 = obs_acc;
        sw_drv[0] = 1'b1; repeat (2) step();
        sw_drv[0] = 1'b0; repeat (12) step();
        chk("glitch_credit", credit, 0);
        chk("glitch_accepts", obs_acc - a0, 0);
        $display("txn glitch: credit=%0d", credit);

        // First coin_100: accepted exactly D+3 cycles after the raw edge.
        a0 = obs_acc;
        sw_drv[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (coin_accepted === 1'b1 && acc_cycle == 0) acc_cycle = k;
        end
        sw_drv[0] = 1'b0; repeat (10) step();
        chk("latency", acc_cycle, D + 3);
        chk("first_accepts", obs_acc - a0, 1);
        chk("credit_1", credit, 1);
        press(1);
        chk("credit_6", credit, 6);
        $display("txn coin_100+coin_500: credit=%0d latency=%0d", credit, acc_cycle);

        // Overflow rejection.
        r0 = obs_rej;
        press(1);
        chk("ovf_credit", credit, 6);
        chk("ovf_reject", obs_rej - r0, 1);
        press(0); press(0); press(0);
        chk("credit_9", credit, 9);
        r0 = obs_rej;
        press(0);
        chk("credit_9_hold", credit, 9);
        chk("reject_at_max", obs_rej - r0, 1);
        $display("txn overflow: credit=%0d", credit);
        press(3);
        chk("refund_9", last_ramt, 9);

        // Simultaneous coins.
        a0 = obs_acc;
        sw_drv[0] = 1'b1; sw_drv[1] = 1'b1;
        repeat (10) step();
        sw_drv[0] = 1'b0; sw_drv[1] = 1'b0;
        repeat (10) step();
        chk("simul_credit", credit, 6);
        chk("simul_accepts", obs_acc - a0, 2);
        $display("txn simultaneous coins: credit=%0d", credit);
        press(3);

        // Vend handshake with a coin during REQUEST.
        press(0); press(0); press(0);
        chk("credit_3", credit, 3);
        press(2);
        chk("req_vend_req", vend_req, 1);
        chk("req_busy", busy, 1);
        r0 = obs_rej;
        press(0);
        chk("req_coin_reject", obs_rej - r0, 1);
        chk("req_credit_frozen", credit, 3);
        repeat (5) step();
        vend_ack = 1'b1; step();
        vend_ack = 1'b0; step();
        chk("ack_vend_req", vend_req, 0);
        chk("ack_credit", credit, 0);
        chk("ack_busy", busy, 0);
        $display("txn vend: credit=%0d vend_req=%0d", credit, vend_req);

        // Refund of 7.
        press(1); press(0); press(0);
        chk("credit_7", credit, 7);
        press(3);
        chk("refund_7", last_ramt, 7);
        chk("refund_credit", credit, 0);
        $display("txn refund: amount=%0d", last_ramt);

        // Reset during REQUEST.
        press(0); press(2);
        chk("pre_reset_req", vend_req, 1);
        reset = 1'b1; step();
        chk("rst_vend_req", vend_req, 0);
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0; step();
        $display("txn reset in request: credit=%0d", credit);

        // Random switch activity against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) sw_drv[i] = ~sw_drv[i];
            vend_ack = ($urandom_range(0, 3) == 0);
            reset    = (c == 700);
            step();
        end
        reset = 1'b0; vend_ack = 1'b0;
        $display("txn random: accepts=%0d rejects=%0d", obs_acc, obs_rej);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/coin_credit_front_end.md
Name: coin_credit_front_end

Overview:
- Upstream stage of the vending datapath.
- Conditions the raw slide-switch inputs (coin_100, coin_500, confirm, cancel): synchronise, debounce, rising-edge detect.
- Accumulates inserted credit in 100-units with overflow rejection.
- Hands one stable credit value to the coffee-selection/change logic through a request/acknowledge handshake, with cancel/refund support.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clock cycles required before a switch level is accepted (10 ms at 50 MHz).
- MAX_CREDIT, 9, maximum credit in 100-units; single-digit 7-seg display limit.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- coin_100_sw  input  1  raw switch; each accepted rising edge inserts 100
- coin_500_sw  input  1  raw switch; each accepted rising edge inserts 500
- confirm_sw  input  1  raw switch; rising edge requests vend
- cancel_sw  input  1  raw switch; rising edge requests refund
- vend_ack  input  1  downstream has latched credit; pulse or level
- credit  output  4  current credit, 100-units (0..MAX_CREDIT)
- vend_req  output  1  held high while awaiting vend_ack
- refund_valid  output  1  one-cycle pulse; refund_amount valid
- refund_amount  output  4  credit returned on cancel
- coin_accepted  output  1  one-cycle pulse per credited coin
- coin_rejected  output  1  one-cycle pulse per rejected coin
- busy  output  1  high when state is not IDLE or COLLECTING

Behaviour:
- Reset, applied on the clock edge while reset=1:
  - All outputs go to 0 and state goes to IDLE.
  - Synchroniser and debounce stable levels go to 0; debounce counters clear.
  - Reset mid-handshake drops vend_req and discards credit without refund.
- Conditioning (per switch):
  - Two-flop synchroniser.
  - Counter increments while the synchronised value differs from the stable level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable takes the new value and the counter clears.
  - Edge pulse = stable & ~stable_d, one cycle.
  - Latency: a raw level held from edge N yields the pulse in cycle N+DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- States: IDLE (credit==0), COLLECTING, REQUEST, REFUND.
- Coin insertion (IDLE/COLLECTING only):
  - Value v = 1 (coin_100) or 5 (coin_500).
  - If credit+v <= MAX_CREDIT: credit += v next cycle, pulse coin_accepted, go to COLLECTING.
  - Otherwise: pulse coin_rejected and leave credit unchanged.
  - The addition is computed 5 bits wide to avoid wrap.
- Simultaneous coin pulses:
  - coin_500 is processed first.
  - coin_100 is latched in a one-deep pending flag and processed the following cycle, with independent accept/reject.
  - A new coin_100 pulse arriving while pending is set is rejected.
- Coins arriving in REQUEST or REFUND: pulse coin_rejected; credit unchanged.
- confirm in COLLECTING:
  - Go to REQUEST with vend_req=1; credit is frozen.
  - confirm in IDLE is ignored, since no vend is allowed with zero credit.
- REQUEST:
  - Hold vend_req until vend_ack is sampled high.
  - On that edge: vend_req=0, credit=0, state IDLE.
  - cancel in REQUEST is ignored.
  - vend_ack outside REQUEST is ignored.
- cancel in COLLECTING:
  - Go to REFUND: refund_amount=credit and refund_valid=1 for exactly one cycle.
  - Next cycle: credit=0, refund_amount=0, state IDLE.
  - cancel in IDLE is ignored.
- confirm and cancel in the same cycle: cancel wins.
- A coin and confirm in the same cycle:
  - The coin is applied first (same edge).
  - Then REQUEST is entered with the updated credit.
- A coin and cancel in the same cycle: the coin is rejected, then refund proceeds.
- busy = (state==REQUEST) | (state==REFUND).

Decomposition:
- Package coin_pkg:
  - CREDIT_W=4.
  - Coin value constants COIN_100_UNITS=1, COIN_500_UNITS=5.
  - Typedef enum fe_state_t {IDLE, COLLECTING, REQUEST, REFUND}.
- Sub-module switch_debouncer (synchroniser + debounce counter + edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.
- Top module holds the FSM, credit register and pending flag.

Test Plan:
1. Reset, then a 2-cycle glitch on coin_100_sw with DEBOUNCE_CYCLES=4 -> no coin_accepted; credit stays 0.
2. coin_100 held 10 cycles -> single coin_accepted at cycle 7 after the raw edge; credit 0->1. Then coin_500 -> credit 6.
3. Credit 6, insert coin_500 -> coin_rejected and credit stays 6. Then 3× coin_100 -> credit 9; a 4th coin_100 -> rejected.
4. Simultaneous coin_500+coin_100 at credit 0 -> credit 5, then 6 one cycle later; two coin_accepted pulses.
5. Credit 3, confirm -> vend_req=1 and busy=1. A coin inserted meanwhile -> rejected. vend_ack after 5 cycles -> vend_req=0, credit=0, IDLE.
6. Credit 7, cancel -> refund_valid one cycle with refund_amount=7, then credit=0. Separately, reset asserted during REQUEST -> all outputs 0 on the next edge.
